// File: rtl/nonogram_pkg.sv
// Shared constants, assignment-word layout and parser states for the nonogram
// clue parser.
package nonogram_pkg;

  localparam int MAX_DIM  = 15;
  localparam int DIM_W    = $clog2(MAX_DIM + 1);
  localparam int ASSIGN_W = 13;

  localparam int IS_COL_BIT   = 12;
  localparam int LINE_LSB     = 8;
  localparam int CLUE_IDX_LSB = 4;
  localparam int CLUE_VAL_LSB = 0;

  typedef enum logic [2:0] {
    S_ROWS,
    S_COLS,
    S_COUNT,
    S_CLUE,
    S_DONE
  } parser_state_t;

  function automatic logic [ASSIGN_W-1:0] pack_assignment(
    input logic             is_col,
    input logic [DIM_W-1:0] line_idx,
    input logic [DIM_W-1:0] clue_idx,
    input logic [DIM_W-1:0] clue_val
  );
    logic [ASSIGN_W-1:0] word;
    word                              = '0;
    word[IS_COL_BIT]                  = is_col;
    word[LINE_LSB     +: DIM_W]       = line_idx;
    word[CLUE_IDX_LSB +: DIM_W]       = clue_idx;
    word[CLUE_VAL_LSB +: DIM_W]       = clue_val;
    return word;
  endfunction

endpackage

// File: rtl/nonogram_parser.sv
// Byte-stream parser turning nonogram board descriptions into one 13-bit clue
// assignment per write strobe, with a pulse once the whole board is consumed.
//
// state   | meaning
// S_ROWS  | waiting for row count R
// S_COLS  | waiting for column count C
// S_COUNT | waiting for clue count K of the current line
// S_CLUE  | waiting for clue values of the current line
// S_DONE  | board finished (done pulse visible); accepts the next R at once
module nonogram_parser
  import nonogram_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_in,
  input  logic                valid_in,
  output logic                board_done,
  output logic                write_ready,
  output logic [ASSIGN_W-1:0] assignment
);

  parser_state_t       state, state_n;
  logic [DIM_W-1:0]    rows_r, rows_n;
  logic [DIM_W-1:0]    cols_r, cols_n;
  logic [DIM_W-1:0]    line_r, line_n;
  logic [DIM_W-1:0]    clue_idx_r, clue_idx_n;
  logic [DIM_W-1:0]    count_r, count_n;
  logic                is_col_r, is_col_n;
  logic                done_n, wr_n;
  logic [ASSIGN_W-1:0] assign_n;

  logic [DIM_W-1:0]    nib;
  logic                last_line;
  logic                advance;
  logic                unused_byte_hi;

  assign nib            = byte_in[DIM_W-1:0];
  assign unused_byte_hi = ^byte_in[7:DIM_W];
  assign last_line      = is_col_r ? (line_r == cols_r - 4'd1)
                                   : (line_r == rows_r - 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_ROWS;
      rows_r      <= '0;
      cols_r      <= '0;
      line_r      <= '0;
      clue_idx_r  <= '0;
      count_r     <= '0;
      is_col_r    <= 1'b0;
      board_done  <= 1'b0;
      write_ready <= 1'b0;
      assignment  <= '0;
    end else begin
      state       <= state_n;
      rows_r      <= rows_n;
      cols_r      <= cols_n;
      line_r      <= line_n;
      clue_idx_r  <= clue_idx_n;
      count_r     <= count_n;
      is_col_r    <= is_col_n;
      board_done  <= done_n;
      write_ready <= wr_n;
      assignment  <= assign_n;
    end
  end

  always_comb begin
    state_n    = state;
    rows_n     = rows_r;
    cols_n     = cols_r;
    line_n     = line_r;
    clue_idx_n = clue_idx_r;
    count_n    = count_r;
    is_col_n   = is_col_r;
    done_n     = 1'b0;
    wr_n       = 1'b0;
    assign_n   = assignment;
    advance    = 1'b0;

    // S_DONE takes a new R directly so back-to-back boards lose no byte
    if (state == S_DONE && !valid_in) begin
      state_n = S_ROWS;
    end

    if (valid_in) begin
      case (state)
        S_ROWS, S_DONE: begin
          rows_n  = nib;
          state_n = S_COLS;
        end
        S_COLS: begin
          cols_n = nib;
          if (rows_r == '0 && nib == '0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            is_col_n = (rows_r == '0);
            line_n   = '0;
            state_n  = S_COUNT;
          end
        end
        S_COUNT: begin
          count_n    = nib;
          clue_idx_n = '0;
          if (nib != '0) begin
            state_n = S_CLUE;
          end else begin
            wr_n     = 1'b1;
            assign_n = pack_assignment(is_col_r, line_r, '0, '0);
            advance  = 1'b1;
          end
        end
        S_CLUE: begin
          wr_n     = 1'b1;
          assign_n = pack_assignment(is_col_r, line_r, clue_idx_r, nib);
          if (clue_idx_r == count_r - 4'd1) begin
            advance = 1'b1;
          end else begin
            clue_idx_n = clue_idx_r + 4'd1;
          end
        end
        default: state_n = S_ROWS;
      endcase
    end

    if (advance) begin
      if (last_line) begin
        if (!is_col_r && cols_r != '0) begin
          is_col_n = 1'b1;
          line_n   = '0;
          state_n  = S_COUNT;
        end else begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end else begin
        line_n  = line_r + 4'd1;
        state_n = S_COUNT;
      end
    end
  end

endmodule

// File: tb/tb_nonogram_parser.sv
// Scoreboard bench for nonogram_parser: expected {done, word} entries are queued
// as streams are driven and compared against what the monitor captured.
module tb_nonogram_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        valid_in;
  logic        board_done;
  logic        write_ready;
  logic [12:0] assignment;

  int tests;
  int failed;
  int done_cnt;

  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];

  nonogram_parser dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .valid_in   (valid_in),
    .board_done (board_done),
    .write_ready(write_ready),
    .assignment (assignment)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (write_ready) obs_q.push_back({board_done, assignment});
      if (board_done) done_cnt++;
    end
  end

  task automatic drive_stream(input logic [7:0] s[$], input int max_gap);
    foreach (s[i]) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 1);
        repeat (g) begin
          valid_in = 1'b0;
          byte_in  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      valid_in = 1'b1;
      byte_in  = s[i];
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    byte_in  = 8'h00;
  endtask

  task automatic wait_outputs(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while (obs_q.size() < n && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (write_ready !== 1'b0) begin
      failed++; $display("FAIL reset_write_ready got %b want 0", write_ready);
    end
    tests++;
    if (board_done !== 1'b0) begin
      failed++; $display("FAIL reset_board_done got %b want 0", board_done);
    end
    tests++;
    if (assignment !== 13'h0000) begin
      failed++; $display("FAIL reset_assignment got %h want 0000", assignment);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_2x2(input string name, input int max_gap);
    logic [7:0]  s[$];
    logic [13:0] e, o;
    bit ok;
    clear_sb();
    s = '{8'h02, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01};
    exp_q = '{{1'b0, 13'h0002}, {1'b0, 13'h0101}, {1'b0, 13'h1002}, {1'b1, 13'h1101}};
    drive_stream(s, max_gap);
    wait_outputs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL %s_timeout got %0d words want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'bx;
      tests++;
      if (o !== e) begin
        failed++; $display("FAIL %s_word%0d got done=%b word=%h want done=%b word=%h", name, i, o[13], o[12:0], e[13], e[12:0]);
      end
    end
    tests++;
    if (obs_q.size() != 0 || done_cnt != 1) begin
      failed++; $display("FAIL %s_extra got %0d extra words %0d done pulses want 0 and 1", name, obs_q.size(), done_cnt);
    end
  endtask

  task automatic test_empty_line();
    logic [7:0]  s[$];
    logic [13:0] e, o;
    bit ok;
    clear_sb();
    s = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h01};
    exp_q = '{{1'b0, 13'h0000}, {1'b1, 13'h1001}};
    drive_stream(s, 0);
    wait_outputs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL empty_timeout got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'bx;
      tests++;
      if (o !== e) begin
        failed++; $display("FAIL empty_word%0d got done=%b word=%h want done=%b word=%h", i, o[13], o[12:0], e[13], e[12:0]);
      end
    end
    tests++;
    if (obs_q.size() != 0 || done_cnt != 1) begin
      failed++; $display("FAIL empty_extra got %0d extra words %0d done pulses want 0 and 1", obs_q.size(), done_cnt);
    end
  endtask

  task automatic test_zero_board();
    logic [7:0] s[$];
    clear_sb();
    s = '{8'h00, 8'h00};
    drive_stream(s, 0);
    @(negedge clk);
    tests++;
    if (board_done !== 1'b1) begin
      failed++; $display("FAIL zero_done_pulse got %b want 1", board_done);
    end
    @(negedge clk);
    tests++;
    if (board_done !== 1'b0) begin
      failed++; $display("FAIL zero_done_width got %b want 0", board_done);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs_q.size() != 0 || done_cnt != 1) begin
      failed++; $display("FAIL zero_words got %0d words %0d done pulses want 0 and 1", obs_q.size(), done_cnt);
    end
  endtask

  // Clue fields only use the low nibble; also covers R>0,C=0 and R=0,C>0.
  task automatic test_multi_clue();
    logic [7:0]  s[$];
    logic [13:0] e, o;
    bit ok;
    clear_sb();
    s = '{8'h01, 8'h00, 8'h13, 8'hF5, 8'hA7, 8'h0F,
          8'h30, 8'hC1, 8'h01, 8'h09};
    exp_q = '{{1'b0, 13'h0005}, {1'b0, 13'h0017}, {1'b1, 13'h002F},
              {1'b1, 13'h1009}};
    drive_stream(s, 0);
    wait_outputs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL multi_timeout got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'bx;
      tests++;
      if (o !== e) begin
        failed++; $display("FAIL multi_word%0d got done=%b word=%h want done=%b word=%h", i, o[13], o[12:0], e[13], e[12:0]);
      end
    end
    tests++;
    if (obs_q.size() != 0 || done_cnt != 2) begin
      failed++; $display("FAIL multi_extra got %0d extra words %0d done pulses want 0 and 2", obs_q.size(), done_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0]  s[$];
    logic [13:0] e, o;
    bit ok;
    clear_sb();
    s = '{8'h02, 8'h02, 8'h01, 8'h02, 8'h01};
    drive_stream(s, 0);
    rst = 1'b0;
    #1;
    tests++;
    if (write_ready !== 1'b0 || board_done !== 1'b0 || assignment !== 13'h0000) begin
      failed++; $display("FAIL midreset_outputs got wr=%b done=%b word=%h want 0 0 0000", write_ready, board_done, assignment);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_sb();
    @(posedge clk); #1;
    s = '{8'h02, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01};
    exp_q = '{{1'b0, 13'h0002}, {1'b0, 13'h0101}, {1'b0, 13'h1002}, {1'b1, 13'h1101}};
    drive_stream(s, 0);
    wait_outputs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL midreset_timeout got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'bx;
      tests++;
      if (o !== e) begin
        failed++; $display("FAIL midreset_word%0d got done=%b word=%h want done=%b word=%h", i, o[13], o[12:0], e[13], e[12:0]);
      end
    end
    tests++;
    if (obs_q.size() != 0 || done_cnt != 1) begin
      failed++; $display("FAIL midreset_extra got %0d extra words %0d done pulses want 0 and 1", obs_q.size(), done_cnt);
    end
  endtask

  task automatic test_back_to_back(input string name, input bit zero_first);
    logic [7:0]  s[$];
    logic [13:0] e, o;
    bit ok;
    clear_sb();
    if (zero_first) begin
      s = '{8'h00, 8'h00,
            8'h02, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01};
      exp_q = '{{1'b0, 13'h0002}, {1'b0, 13'h0101}, {1'b0, 13'h1002}, {1'b1, 13'h1101}};
    end else begin
      s = '{8'h02, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01,
            8'h01, 8'h01, 8'h00, 8'h01, 8'h01};
      exp_q = '{{1'b0, 13'h0002}, {1'b0, 13'h0101}, {1'b0, 13'h1002}, {1'b1, 13'h1101},
                {1'b0, 13'h0000}, {1'b1, 13'h1001}};
    end
    drive_stream(s, 0);
    wait_outputs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL %s_timeout got %0d words want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'bx;
      tests++;
      if (o !== e) begin
        failed++; $display("FAIL %s_word%0d got done=%b word=%h want done=%b word=%h", name, i, o[13], o[12:0], e[13], e[12:0]);
      end
    end
    tests++;
    if (obs_q.size() != 0 || done_cnt != 2) begin
      failed++; $display("FAIL %s_extra got %0d extra words %0d done pulses want 0 and 2", name, obs_q.size(), done_cnt);
    end
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    done_cnt = 0;
    test_reset();
    test_basic_2x2("basic", 0);
    test_empty_line();
    test_zero_board();
    test_multi_clue();
    test_basic_2x2("gaps", 5);
    test_reset_midstream();
    test_back_to_back("b2b", 1'b0);
    test_back_to_back("zero_b2b", 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nonogram_parser.md
Name: nonogram_parser

Overview:
Byte-stream parser for nonogram puzzle descriptions arriving from the UART receiver. It decodes board dimensions and per-line clue lists. Each clue is emitted as one 13-bit assignment word, with a one-cycle write strobe, to the clue BRAM writer. It signals when the whole board has been consumed, and sits between the UART RX byte interface and the clue-memory/solver front end.

Parameters:
MAX_DIM, 15, maximum rows/columns; dimension, count and clue fields are 4 bits wide.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
byte_in  input  8  received byte, sampled only when valid_in=1
valid_in  input  1  one byte accepted per clk cycle while high
board_done  output  1  one-cycle pulse: full board parsed
write_ready  output  1  one-cycle pulse: assignment valid, write it to BRAM
assignment  output  13  {is_col[12], line_idx[11:8], clue_idx[7:4], clue_val[3:0]}

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst=0 resets, independent of clk).
  - On reset: board_done=0, write_ready=0, assignment=13'h0; all counters cleared; state=S_ROWS.
  - Reset mid-stream discards the partial board; no done pulse.
- Cycles with valid_in=0 are ignored, with no state change. Gaps of any length between bytes are legal.
- Only byte_in[3:0] is used for every field; bits [7:4] are ignored.
- Stream format per board:
  - R (rows), then C (cols).
  - Then R row records, followed by C column records, in index order 0..R-1 and 0..C-1.
  - Record = count K, followed by K clue value bytes.
- States:
  - S_ROWS: latch R → S_COLS.
  - S_COLS: latch C. If R=0 and C=0 → S_DONE. Else set is_col = (R==0), line_idx=0 → S_COUNT.
  - S_COUNT: latch K, clue_idx=0.
    - K≥1 → S_CLUE.
    - K=0: emit one word {is_col, line_idx, 0, 0} marking an empty line, then advance line (see below).
  - S_CLUE: emit {is_col, line_idx, clue_idx, val}; clue_idx++. When clue_idx reaches K-1, advance line.
  - Advance line:
    - If line_idx is the last line of the current set (R-1 for rows, C-1 for cols):
      - Rows done and C>0 → is_col=1, line_idx=0, S_COUNT.
      - Otherwise → board complete.
    - Else line_idx++, S_COUNT.
  - S_DONE: pulse board_done for one cycle → S_ROWS, ready for the next board immediately.
- Outputs are registered.
  - write_ready and assignment update on the clk edge that accepts the clue (or K=0) byte, i.e. visible the cycle after valid_in.
  - assignment holds its value until the next write.
- board_done timing:
  - For a non-empty board, board_done pulses in the same cycle as the final write_ready.
  - For a 0x0 board, board_done pulses the cycle after C is accepted.
- Back-to-back bytes at one per cycle must be sustained without loss.
- Counts and values are not range-checked. Clue values 0..15 pass through. K up to 15 is accepted.

Decomposition:
- Package nonogram_pkg holds:
  - MAX_DIM.
  - Field width constants: DIM_W=4, ASSIGN_W=13.
  - Field bit positions of assignment.
  - Parser state enum: S_ROWS, S_COLS, S_COUNT, S_CLUE, S_DONE.
- Single module; no sub-module needed.

Test Plan:
- 2x2 board, stream 02 02 01 02 01 01 01 02 01 01 with valid_in high continuously:
  - four write_ready pulses with assignment 13'h0002, 13'h0101, 13'h1002, 13'h1101;
  - board_done high together with the last one.
- Empty line, stream 01 01 00 01 01:
  - words 13'h0000 (row0 empty) then 13'h1001;
  - board_done with the second.
- 0x0 board, stream 00 00:
  - no write_ready;
  - board_done pulses one cycle after the second byte.
- Same 2x2 stream with random 1–5 cycle valid_in gaps and garbage byte_in during gaps:
  - identical assignments and board_done.
- Reset pulse (rst=0) after 5 bytes of the 2x2 stream:
  - outputs 0 immediately;
  - a subsequent full stream parses correctly, with no stale words.
- Two boards back-to-back with no idle cycle:
  - both produce the correct word sequences;
  - exactly two board_done pulses.
